fp_sqrt: RTL and testbench



---
 rtl/fp_sqrt_pkg.sv | 23 ++
 rtl/fp_sqrt_if.sv | 21 ++
 rtl/int_sqrt.sv | 79 +++++++
 rtl/fp_sqrt.sv | 226 ++++++++++++++++++++++
 tb/tb_fp_sqrt.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg
// Shared types and constants for the binary32 square-root operator.
// Contents: FSM state encoding, exponent bias, special result encodings,
// radicand/root widths of the integer core, and the normal-path latency.
package fp_sqrt_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_ROUND  = 3'd4
    } state_e;

    localparam int          FP_W    = 32;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] PINF    = 32'h7F80_0000;
    localparam int          RAD_W   = 52;
    localparam int          ROOT_W  = 26;
    localparam int          LATENCY = 30;

endpackage

// File: rtl/fp_sqrt_if.sv
// fp_sqrt_if
// Request/result bundle of the square-root operator.
//   start   : one-cycle request, only honoured while done is high
//   op      : binary32 operand, sampled with start
//   done    : level, high while the operator is idle and results are valid
//   res     : binary32 result
//   invalid : IEEE invalid flag of the last operation
// master = requester, slave = fp_sqrt.
interface fp_sqrt_if;
    import fp_sqrt_pkg::*;

    logic            start;
    logic [FP_W-1:0] op;
    logic            done;
    logic [FP_W-1:0] res;
    logic            invalid;

    modport master (output start, output op, input done, input res, input invalid);
    modport slave  (input start, input op, output done, output res, output invalid);

endinterface

// File: rtl/int_sqrt.sv
// int_sqrt
// Multi-cycle restoring integer square root, one root bit per clock.
// The radicand is treated as DATA_W integer bits with FRACTIONAL_W extra
// fractional bits appended; DATA_W+FRACTIONAL_W must be even.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_start      : load radicand and begin (ignored while busy)
//   i_radicand   : DATA_W-bit radicand
//   o_done       : high while idle; o_root valid after a run
//   o_root       : floor(sqrt(radicand)), (DATA_W+FRACTIONAL_W)/2 bits
// A run takes one load edge plus ROOT_W iteration edges; o_done rises on the
// last iteration edge.
module int_sqrt #(
    parameter int DATA_W       = 52,
    parameter int FRACTIONAL_W = 0
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic [DATA_W-1:0]                     i_radicand,
    output logic                                  o_done,
    output logic [(DATA_W+FRACTIONAL_W)/2-1:0]    o_root
);

    localparam int XW     = DATA_W + FRACTIONAL_W;
    localparam int ROOT_W = XW / 2;
    localparam int REM_W  = ROOT_W + 2;
    localparam int CNT_W  = $clog2(ROOT_W + 1);

    logic [XW-1:0]     r_x;
    logic [ROOT_W-1:0] r_q;
    logic [REM_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    logic [REM_W-1:0]  w_rem_sh;
    logic [REM_W:0]    w_diff;

    // Bring down the next radicand bit pair and trial-subtract 4q+1.
    // The remainder never exceeds 2q, so the two bits dropped off the top of
    // r_rem by the shift are always zero.
    assign w_rem_sh = {r_rem[REM_W-3:0], r_x[XW-1:XW-2]};
    assign w_diff   = {1'b0, w_rem_sh} - {1'b0, r_q, 2'b01};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x    <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_x    <= XW'(i_radicand) << FRACTIONAL_W;
                r_q    <= '0;
                r_rem  <= '0;
                r_cnt  <= CNT_W'(ROOT_W);
                r_busy <= 1'b1;
            end
        end else begin
            r_x   <= {r_x[XW-3:0], 2'b00};
            r_cnt <= r_cnt - CNT_W'(1);
            if (!w_diff[REM_W]) begin
                r_rem <= w_diff[REM_W-1:0];
                r_q   <= {r_q[ROOT_W-2:0], 1'b1};
            end else begin
                r_rem <= w_rem_sh;
                r_q   <= {r_q[ROOT_W-2:0], 1'b0};
            end
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = ~r_busy;
    assign o_root = r_q;

endmodule

// File: rtl/fp_sqrt.sv
// fp_sqrt
// IEEE-754 binary32 square root, round to nearest, built on int_sqrt.
// Ports:
//   i_clk : clock
//   i_rst : asynchronous active-high reset
//   bus   : fp_sqrt_if.slave (start, op in; done, res, invalid out)
// Build option:
//   FP_SQRT_DENORM_EN defined   -> subnormal operands are normalised and
//                                  take the full 30-cycle path.
//   FP_SQRT_DENORM_EN undefined -> subnormal operands flush to a signed zero
//                                  in one cycle; no leading-zero logic.
//
// state  | meaning
// IDLE   | done high, waiting for start
// UNPACK | screen specials, build radicand and halved exponent
// ISSUE  | one-cycle start to the integer core
// WAIT   | core iterating, wait for its done
// ROUND  | round root to nearest, pack and write result
module fp_sqrt
    import fp_sqrt_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    fp_sqrt_if.slave     bus
);

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    state_e              r_state, w_state_nxt;
    logic [FP_W-1:0]     r_op, w_op_nxt;
    logic [RAD_W-1:0]    r_rad, w_rad_nxt;
    logic signed [9:0]   r_exp_half, w_exp_half_nxt;
    logic [FP_W-1:0]     r_res, w_res_nxt;
    logic                r_invalid, w_invalid_nxt;

    logic                w_core_start;
    logic                w_core_done;
    logic [ROOT_W-1:0]   w_root;

    // ---------------- operand fields ----------------
    logic                w_sign;
    logic [7:0]          w_exp_f;
    logic [22:0]         w_frac;
    logic                w_exp_zero, w_exp_ones, w_frac_zero;

    assign w_sign      = r_op[31];
    assign w_exp_f     = r_op[30:23];
    assign w_frac      = r_op[22:0];
    assign w_exp_zero  = (w_exp_f == 8'h00);
    assign w_exp_ones  = (w_exp_f == 8'hFF);
    assign w_frac_zero = (w_frac == 23'd0);

    // ---------------- mantissa / unbiased exponent ----------------
    logic [23:0]         w_m;
    logic signed [9:0]   w_e;

`ifdef FP_SQRT_DENORM_EN
    localparam logic FLUSH_SUB = 1'b0;
    logic [4:0] w_shift;

    // Shift that moves the leading one of a subnormal fraction to bit 23.
    always_comb begin
        w_shift = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (w_frac[i]) begin
                w_shift = 5'(23 - i);
            end
        end
        if (w_exp_zero) begin
            w_m = {1'b0, w_frac} << w_shift;
            w_e = -10'sd126 - $signed({5'b00000, w_shift});
        end else begin
            w_m = {1'b1, w_frac};
            w_e = $signed({2'b00, w_exp_f}) - BIAS_S;
        end
    end
`else
    localparam logic FLUSH_SUB = 1'b1;

    always_comb begin
        w_m = {1'b1, w_frac};
        w_e = $signed({2'b00, w_exp_f}) - BIAS_S;
    end
`endif

    // ---------------- special operand screen ----------------
    logic                w_special;
    logic [FP_W-1:0]     w_special_res;
    logic                w_special_inv;

    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        w_special_inv = 1'b0;
        if (w_exp_ones && !w_frac_zero) begin
            w_special     = 1'b1;
            w_special_res = QNAN;
        end else if (w_exp_zero && w_frac_zero) begin
            w_special     = 1'b1;
            w_special_res = r_op;
        end else if (FLUSH_SUB && w_exp_zero) begin
            w_special     = 1'b1;
            w_special_res = {w_sign, 31'd0};
        end else if (w_sign) begin
            w_special     = 1'b1;
            w_special_res = QNAN;
            w_special_inv = 1'b1;
        end else if (w_exp_ones) begin
            w_special     = 1'b1;
            w_special_res = PINF;
        end
    end

    // ---------------- radicand build ----------------
    // Make the exponent even by moving one factor of two into the mantissa.
    // The mantissa's weight-1 bit lands on radicand bit 50, so the root's
    // weight-1 bit is root bit 25 and the radicand value lies in [1,4).
    logic                w_odd;
    logic [24:0]         w_m25;
    logic signed [9:0]   w_e_even;
    logic signed [9:0]   w_exp_half;
    logic [RAD_W-1:0]    w_rad;

    assign w_odd      = w_e[0];
    assign w_m25      = w_odd ? {w_m, 1'b0} : {1'b0, w_m};
    assign w_e_even   = w_odd ? (w_e - 10'sd1) : w_e;
    assign w_exp_half = w_e_even >>> 1;
    assign w_rad      = {w_m25, {(RAD_W-25){1'b0}}};

    // ---------------- round and pack ----------------
    // Square roots of binary32 values are never exact ties, so root bit 1
    // alone decides the increment.
    logic [24:0]         w_mant_rnd;
    logic signed [9:0]   w_exp_out;
    logic [FP_W-1:0]     w_round_res;

    assign w_mant_rnd  = {1'b0, w_root[25:2]} + {24'd0, w_root[1]};
    assign w_exp_out   = r_exp_half + BIAS_S + $signed({9'd0, w_mant_rnd[24]});
    assign w_round_res = {1'b0, w_exp_out[7:0], w_mant_rnd[22:0]};

    logic w_unused_bits;
    assign w_unused_bits = ^{w_root[0], w_mant_rnd[23], w_exp_out[9:8]};

    // ---------------- integer core ----------------
    int_sqrt #(
        .DATA_W       (RAD_W),
        .FRACTIONAL_W (0)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_core_start),
        .i_radicand (r_rad),
        .o_done     (w_core_done),
        .o_root     (w_root)
    );

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_rad_nxt      = r_rad;
        w_exp_half_nxt = r_exp_half;
        w_res_nxt      = r_res;
        w_invalid_nxt  = r_invalid;
        w_core_start   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_op_nxt    = bus.op;
                    w_state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (w_special) begin
                    w_res_nxt     = w_special_res;
                    w_invalid_nxt = w_special_inv;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_rad_nxt      = w_rad;
                    w_exp_half_nxt = w_exp_half;
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_core_start = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (w_core_done) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_res_nxt     = w_round_res;
                w_invalid_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rad      <= '0;
            r_exp_half <= '0;
            r_res      <= '0;
            r_invalid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_rad      <= w_rad_nxt;
            r_exp_half <= w_exp_half_nxt;
            r_res      <= w_res_nxt;
            r_invalid  <= w_invalid_nxt;
        end
    end

    assign bus.done    = (r_state == S_IDLE);
    assign bus.res     = r_res;
    assign bus.invalid = r_invalid;

endmodule

// File: tb/tb_fp_sqrt.sv
// tb_fp_sqrt
// Scoreboard bench for fp_sqrt: each request pushes its expected result,
// flag and done-low length; a negedge monitor pops and compares whenever
// done returns high. Honours FP_SQRT_DENORM_EN for the subnormal vectors.
module tb_fp_sqrt;
    import fp_sqrt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_sqrt_if sq_if ();

    fp_sqrt dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sq_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        logic        inv;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   low_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: double-precision sqrt, then round to binary32.
    // The double result carries enough bits that this second rounding is exact.
    function automatic logic [31:0] model_sqrt(input logic [31:0] f);
        logic [63:0] d;
        logic [63:0] q;
        real         r;
        d = {1'b0, {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        r = $sqrt($bitstoreal(d));
        q = $realtobits(r);
        return {1'b0, 8'(q[62:52] - 11'd896), q[51:29]} + {31'd0, q[28]};
    endfunction

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sq_if.done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input logic [31:0] op, input logic [31:0] e_res,
                        input logic e_inv, input int e_lat);
        exp_t e;
        wait_idle();
        e.op = op; e.res = e_res; e.inv = e_inv; e.lat = e_lat;
        sb_q.push_back(e);
        sq_if.start = 1'b1;
        sq_if.op    = op;
        @(posedge clk);
        #1;
        sq_if.start = 1'b0;
        sq_if.op    = $urandom;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            low_cnt = 0;
        end else if (!sq_if.done) begin
            low_cnt++;
        end else if (low_cnt > 0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("res op=%h", e.op), 64'(sq_if.res), 64'(e.res));
                chk($sformatf("invalid op=%h", e.op), 64'(sq_if.invalid), 64'(e.inv));
                chk($sformatf("latency op=%h", e.op), 64'(low_cnt), 64'(e.lat));
            end
            low_cnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] op;
        sq_if.start = 1'b0;
        sq_if.op    = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 64'(sq_if.done), 64'd1);
        chk("rst_res", 64'(sq_if.res), 64'd0);
        chk("rst_invalid", 64'(sq_if.invalid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(32'h4080_0000, 32'h4000_0000, 1'b0, LATENCY);
        send(32'h4000_0000, 32'h3FB5_04F3, 1'b0, LATENCY);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, LATENCY);
        send(32'h4110_0000, 32'h4040_0000, 1'b0, LATENCY);
        send(32'h3E80_0000, 32'h3F00_0000, 1'b0, LATENCY);
        send(32'hBF80_0000, QNAN, 1'b1, 1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1);
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 1);
        send(32'h7F80_0000, PINF, 1'b0, 1);
        send(32'h7FA0_0000, QNAN, 1'b0, 1);
        send(32'hFFC0_0000, QNAN, 1'b0, 1);
        send(32'hFF80_0000, QNAN, 1'b1, 1);
`ifdef FP_SQRT_DENORM_EN
        send(32'h0000_0001, 32'h1A35_04F3, 1'b0, LATENCY);
        send(32'h8000_0001, QNAN, 1'b1, 1);
`else
        send(32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        send(32'h8000_0001, 32'h8000_0000, 1'b0, 1);
`endif

        // start pulsed mid-operation must be ignored
        send(32'h4000_0000, 32'h3FB5_04F3, 1'b0, LATENCY);
        repeat (10) @(posedge clk);
        #1;
        sq_if.start = 1'b1;
        sq_if.op    = 32'hBF80_0000;
        @(posedge clk);
        #1;
        sq_if.start = 1'b0;

        // start held high: back-to-back operations
        wait_idle();
        sb_q.push_back('{op: 32'h4110_0000, res: 32'h4040_0000, inv: 1'b0, lat: LATENCY});
        sb_q.push_back('{op: 32'hBF80_0000, res: QNAN, inv: 1'b1, lat: 1});
        sq_if.start = 1'b1;
        sq_if.op    = 32'h4110_0000;
        @(posedge clk);
        #1;
        sq_if.op = 32'hBF80_0000;
        wait_idle();
        @(posedge clk);
        #1;
        sq_if.start = 1'b0;

        // random positive normals against the reference model
        for (int k = 0; k < 8; k++) begin
            op = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            send(op, model_sqrt(op), 1'b0, LATENCY);
        end

        // reset in the middle of an operation
        send(32'h4000_0000, 32'h3FB5_04F3, 1'b0, LATENCY);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_done", 64'(sq_if.done), 64'd1);
        chk("abort_res", 64'(sq_if.res), 64'd0);
        chk("abort_invalid", 64'(sq_if.invalid), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h4080_0000, 32'h4000_0000, 1'b0, LATENCY);

        for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
